// File: rtl/spi_ram_master.sv
// SPI master for the slave+RAM top: serialises 11-bit frames on SS_n/MOSI
// and, for read-data frames, captures the returned byte from MISO.
module spi_ram_master #(
  parameter int READ_GAP = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE, SEL, SHIFT, TAIL, WAIT, RECV, GAP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(READ_GAP - 2);
  localparam logic [3:0] GAP_INIT  = 4'(IDLE_GAP - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] frame_q;
  logic        rd_q;
  logic [7:0]  sr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) state_d = SEL;
      SEL: begin
        state_d = SHIFT;
        cnt_d   = 4'd10;
      end
      SHIFT: begin
        if (cnt_q == 4'd0) state_d = TAIL;
        else cnt_d = cnt_q - 4'd1;
      end
      TAIL: begin
        if (!rd_q) begin
          state_d = GAP;
          cnt_d   = GAP_INIT;
        end else if (READ_GAP == 1) begin
          state_d = RECV;
          cnt_d   = 4'd0;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RECV;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECV: begin
        if (cnt_q == 4'd7) begin
          state_d = GAP;
          cnt_d   = GAP_INIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      frame_q     <= 11'd0;
      rd_q        <= 1'b0;
      sr_q        <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      SS_n        <= 1'b1;
      MOSI        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy        <= (state_d != IDLE);
      SS_n        <= !(state_d inside {SEL, SHIFT, TAIL, WAIT, RECV});
      done        <= (state_d == GAP) && (state_q != GAP);
      rdata_valid <= (state_q == RECV) && (state_d == GAP);
      MOSI        <= 1'b0;
      if (state_q == IDLE && start) begin
        frame_q <= {cmd[1], cmd, (cmd == 2'b11) ? 8'h00 : wdata};
        rd_q    <= &cmd;
      end
      if (state_d == SHIFT) begin
        MOSI    <= frame_q[10];
        frame_q <= {frame_q[9:0], 1'b0};
      end
      if (state_d == RECV) sr_q <= {sr_q[6:0], MISO};
      if (state_q == RECV && state_d == GAP) rdata <= sr_q;
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with a behavioural SPI slave + RAM model
// and a second instance at READ_GAP=3 against a fixed-byte slave.
module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, rdata_valid, ss_n, mosi;
  logic [7:0] rdata;
  logic       miso = 1'b0;

  logic       start3 = 1'b0;
  logic       busy3, done3, rdata_valid3, ss_n3, mosi3;
  logic [7:0] rdata3;
  logic       miso3 = 1'b0;

  spi_ram_master #(.READ_GAP(2), .IDLE_GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .rdata_valid(rdata_valid), .SS_n(ss_n), .MOSI(mosi),
    .MISO(miso)
  );

  spi_ram_master #(.READ_GAP(3), .IDLE_GAP(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cmd(2'b11),
    .wdata(8'h00), .busy(busy3), .done(done3), .rdata(rdata3),
    .rdata_valid(rdata_valid3), .SS_n(ss_n3), .MOSI(mosi3),
    .MISO(miso3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // slave + RAM model for the READ_GAP=2 instance
  int          scnt = 0;
  logic [10:0] cap = '0;
  logic [10:0] last_frame = '0;
  logic [7:0]  wa = 8'h00;
  logic [7:0]  ra = 8'h00;
  logic [7:0]  txs = 8'h00;
  logic [7:0]  mem [256];

  always @(posedge clk) scnt <= ss_n ? 0 : scnt + 1;

  always @(negedge clk) begin : slave
    logic [10:0] f;
    f = {cap[9:0], mosi};
    if (!rst_n) mem[8'hFE] <= 8'h55;
    if (scnt == 0) cap <= '0;
    else if (scnt <= 11) cap <= f;
    if (scnt == 11) begin
      last_frame <= f;
      case (f[9:8])
        2'b00:   wa <= f[7:0];
        2'b01:   mem[wa] <= f[7:0];
        2'b10:   ra <= f[7:0];
        default: txs <= mem[ra];
      endcase
    end
    if (scnt >= 13 && scnt <= 20) begin
      miso <= txs[7];
      txs  <= {txs[6:0], 1'b0};
    end else begin
      miso <= 1'b0;
    end
  end

  // fixed-byte slave for the READ_GAP=3 instance
  int         scnt3 = 0;
  logic [7:0] t3 = 8'hC3;

  always @(posedge clk) scnt3 <= ss_n3 ? 0 : scnt3 + 1;

  always @(negedge clk) begin
    if (scnt3 >= 14 && scnt3 <= 21) begin
      miso3 <= t3[7];
      t3    <= {t3[6:0], 1'b0};
    end else begin
      miso3 <= 1'b0;
      if (scnt3 == 0) t3 <= 8'hC3;
    end
  end

  // monitor
  int   ss_low = 0;
  int   done_cnt = 0;
  int   done_at = -1;
  logic rv_at_done = 1'b0;
  int   mosi_bad = 0;

  always @(negedge clk) begin
    if (!ss_n) ss_low <= ss_low + 1;
    if (ss_n && mosi) mosi_bad <= mosi_bad + 1;
    if (done) begin
      done_cnt   <= done_cnt + 1;
      done_at    <= cyc - e0;
      rv_at_done <= rdata_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         fr_ss, fr_done, fr_drop;
  logic       fr_busy13;
  logic [7:0] rdata_mid;

  task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                           input bit xs);
    int ss_base, done_base;
    @(negedge clk);
    cmd = c;
    wdata = d;
    start = 1'b1;
    ss_base = ss_low;
    done_base = done_cnt;
    fr_drop = -1;
    fr_busy13 = 1'b0;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    cmd = ~c;
    wdata = ~d;
    for (int k = 1; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (xs && k == 2) begin
        start = 1'b1;
        cmd = 2'b00;
        wdata = 8'h12;
      end
      if (xs && k == 3) start = 1'b0;
      if (k == 13) fr_busy13 = busy;
      if (k == 21) rdata_mid = rdata;
      if (!busy) begin
        fr_drop = k;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    fr_ss = ss_low - ss_base;
    fr_done = done_cnt - done_base;
  endtask

  int   dbase;
  int   d3_k;
  logic rv3_seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_rdata", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(2'b00, 8'hFF, 0);
    chk("wa_frame", last_frame, 11'h0FF);
    chk("wa_ss_low", fr_ss, 13);
    chk("wa_done_at", done_at, 13);
    chk("wa_busy_e13", fr_busy13, 1);
    chk("wa_busy_drop", fr_drop, 14);
    chk("wa_done_cnt", fr_done, 1);

    run_frame(2'b01, 8'h7D, 0);
    chk("wd_frame", last_frame, 11'h17D);
    run_frame(2'b10, 8'hFF, 0);
    chk("ra_frame", last_frame, 11'h6FF);
    run_frame(2'b11, 8'h5C, 0);
    chk("rd_frame", last_frame, 11'h700);
    chk("rd_ss_low", fr_ss, 22);
    chk("rd_done_at", done_at, 22);
    chk("rd_rvalid", rv_at_done, 1);
    chk("rd_busy_drop", fr_drop, 23);
    chk("rd_rdata", rdata, 8'h7D);

    run_frame(2'b00, 8'hFE, 0);
    run_frame(2'b01, 8'hAA, 0);
    chk("hold_after_wd", rdata, 8'h7D);
    run_frame(2'b10, 8'hFE, 0);
    run_frame(2'b11, 8'h00, 0);
    chk("rd2_mid_hold", rdata_mid, 8'h7D);
    chk("rd2_rdata", rdata, 8'hAA);
    chk("rd2_done_at", done_at, 22);

    run_frame(2'b11, 8'h99, 1);
    chk("ign_frame", last_frame, 11'h700);
    chk("ign_done_cnt", fr_done, 1);
    chk("ign_rdata", rdata, 8'hAA);
    chk("ign_busy_after", busy, 0);

    dbase = done_cnt;
    @(negedge clk);
    cmd = 2'b01;
    wdata = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ss_n", ss_n, 1);
    chk("arst_mosi", mosi, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdata", rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_cnt - dbase, 0);
    run_frame(2'b00, 8'h5A, 0);
    chk("post_rst_frame", last_frame, 11'h05A);
    chk("post_rst_done_at", done_at, 13);
    chk("post_rst_ss_low", fr_ss, 13);

    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start3 = 1'b0;
    d3_k = -1;
    rv3_seen = 1'b0;
    for (int k = 1; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        d3_k = k;
        rv3_seen = rdata_valid3;
        break;
      end
    end
    chk("rg3_done_at", d3_k, 23);
    chk("rg3_rvalid", rv3_seen, 1);
    chk("rg3_rdata", rdata3, 8'hC3);

    chk("mosi_idle_zero", mosi_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
